// File: rtl/alu_op_seq_pkg.sv
// Shared types for the ALU ROM operation sequencer: data widths, ALU op-codes and FSM state encoding.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_NOT = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_seq_if.sv
// Bus between the sequencer (master) and the ALU ROM (slave): latched operation out, result and flag strobes back.
interface alu_op_seq_if;
  import alu_seq_pkg::*;

  logic              rom_noe;
  logic [OP_W-1:0]   rom_op;
  logic [DATA_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_b;
  logic              rom_flin;
  logic [DATA_W-1:0] rom_ibus;
  logic              rom_flout;
  logic              rom_nsetl;
  logic              rom_fvout;
  logic              rom_nsetv;

  modport master (
    output rom_noe, rom_op, rom_a, rom_b, rom_flin,
    input  rom_ibus, rom_flout, rom_nsetl, rom_fvout, rom_nsetv
  );

  modport slave (
    input  rom_noe, rom_op, rom_a, rom_b, rom_flin,
    output rom_ibus, rom_flout, rom_nsetl, rom_fvout, rom_nsetv
  );
endinterface

// File: rtl/alu_wait_ctr.sv
// 4-bit down-counter timing the ROM access window: load, decrement, zero flag.
module alu_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/alu_op_seq.sv
// Sequences one ALU operation through an asynchronous ALU ROM: latch, settle, timed access, capture.
// Optional macro ALU_FLAG_WRITE_EN adds direct fl/fv write ports (CAPTURE load wins over them).
module alu_op_seq
  import alu_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flin,
`ifdef ALU_FLAG_WRITE_EN
  input  logic              fl_we,
  input  logic              fl_d,
  input  logic              fv_we,
  input  logic              fv_d,
`endif
  alu_op_seq_if.master      rom,
  output logic [DATA_W-1:0] result,
  output logic              fl,
  output logic              fv,
  output logic              busy,
  output logic              done
);

  // Counter is preloaded with WAIT_CYCLES-1 so ACCESS ends on the cycle it reads zero.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state_reg;
  logic              noe_reg;
  logic [OP_W-1:0]   op_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              flin_reg;
  logic [DATA_W-1:0] result_reg;
  logic              fl_reg;
  logic              fv_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              ctr_zero;

  alu_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (state_reg == SETUP),
    .load_val (WAIT_LOAD),
    .dec      (state_reg == ACCESS),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      noe_reg    <= 1'b1;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      flin_reg   <= 1'b0;
      result_reg <= '0;
      fl_reg     <= 1'b0;
      fv_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
`ifdef ALU_FLAG_WRITE_EN
      if (fl_we) fl_reg <= fl_d;
      if (fv_we) fv_reg <= fv_d;
`endif
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg    <= op;
            a_reg     <= a;
            b_reg     <= b;
            flin_reg  <= flin;
            busy_reg  <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          noe_reg   <= 1'b0;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (ctr_zero) state_reg <= CAPTURE;
        end
        CAPTURE: begin
          result_reg <= rom.rom_ibus;
          if (!rom.rom_nsetl) fl_reg <= rom.rom_flout;
          if (!rom.rom_nsetv) fv_reg <= rom.rom_fvout;
          noe_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rom.rom_noe  = noe_reg;
  assign rom.rom_op   = op_reg;
  assign rom.rom_a    = a_reg;
  assign rom.rom_b    = b_reg;
  assign rom.rom_flin = flin_reg;
  assign result       = result_reg;
  assign fl           = fl_reg;
  assign fv           = fv_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_alu_op_seq.sv
// Scoreboard bench for alu_op_seq with a behavioural ALU ROM; covers timing, flags, back-to-back, ignore and abort.
module tb_alu_op_seq;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic        fl;
    logic        fv;
    logic [15:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        flin = 1'b0;
  logic [15:0] result;
  logic        fl, fv, busy, done;
`ifdef ALU_FLAG_WRITE_EN
  logic        fl_we = 1'b0, fl_d = 1'b0, fv_we = 1'b0, fv_d = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   exp_dones = 0;
  exp_t exp_q[$];
  logic mfl, mfv;

  alu_op_seq_if rom_bus();

  alu_op_seq #(.WAIT_CYCLES(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flin   (flin),
`ifdef ALU_FLAG_WRITE_EN
    .fl_we  (fl_we),
    .fl_d   (fl_d),
    .fv_we  (fv_we),
    .fv_d   (fv_d),
`endif
    .rom    (rom_bus),
    .result (result),
    .fl     (fl),
    .fv     (fv),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU ROM: drives results only while output-enabled; logic ops leave flags alone.
  always_comb begin
    logic [16:0] sum;
    sum                = 17'd0;
    rom_bus.rom_ibus   = 16'd0;
    rom_bus.rom_flout  = 1'b0;
    rom_bus.rom_fvout  = 1'b0;
    rom_bus.rom_nsetl  = 1'b1;
    rom_bus.rom_nsetv  = 1'b1;
    if (!rom_bus.rom_noe) begin
      case (rom_bus.rom_op)
        3'b000: begin
          sum = {1'b0, rom_bus.rom_a} + {1'b0, rom_bus.rom_b} + {16'd0, rom_bus.rom_flin};
          rom_bus.rom_ibus  = sum[15:0];
          rom_bus.rom_flout = sum[16];
          rom_bus.rom_fvout = (rom_bus.rom_a[15] == rom_bus.rom_b[15]) && (sum[15] != rom_bus.rom_a[15]);
          rom_bus.rom_nsetl = 1'b0;
          rom_bus.rom_nsetv = 1'b0;
        end
        3'b001: rom_bus.rom_ibus = rom_bus.rom_a & rom_bus.rom_b;
        3'b010: rom_bus.rom_ibus = rom_bus.rom_a | rom_bus.rom_b;
        3'b011: rom_bus.rom_ibus = rom_bus.rom_a ^ rom_bus.rom_b;
        3'b100: rom_bus.rom_ibus = ~rom_bus.rom_a;
        default: rom_bus.rom_ibus = 16'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_alu(input logic [2:0] o, input logic [15:0] xa, xb,
                                   input logic xf, input logic cur_fl, cur_fv);
    exp_t        e;
    logic [16:0] s;
    e.fl = cur_fl;
    e.fv = cur_fv;
    s    = {1'b0, xa} + {1'b0, xb} + {16'd0, xf};
    case (o)
      3'b000: begin
        e.res = s[15:0];
        e.fl  = s[16];
        e.fv  = (xa[15] == xb[15]) && (s[15] != xa[15]);
      end
      3'b001:  e.res = xa & xb;
      3'b010:  e.res = xa | xb;
      3'b011:  e.res = xa ^ xb;
      default: e.res = ~xa;
    endcase
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_spurious", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {16'd0, result}, {16'd0, e.res});
        check("fl", {31'd0, fl}, {31'd0, e.fl});
        check("fv", {31'd0, fv}, {31'd0, e.fv});
      end
      $display("done: result=%h fl=%b fv=%b", result, fl, fv);
    end
  end

  // Starts one operation from the current cycle and returns in its done cycle.
  task automatic op_timed(input logic [2:0] o, input logic [15:0] xa, xb, input logic xf,
                          input logic [15:0] er, input logic efl, efv, input bit glitch);
    int k;
    int low;
    bit seen;
    exp_q.push_back('{fl: efl, fv: efv, res: er});
    exp_dones++;
    op = o; a = xa; b = xb; flin = xf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    low = 0; seen = 1'b0; k = 1;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (!rom_bus.rom_noe) low++;
      if (glitch && k == 2) begin start = 1'b1; a = 16'h1234; b = 16'h5678; end
      if (glitch && k == 3) start = 1'b0;
      if (glitch && k == 4) begin
        check("rom_a_hold", {16'd0, rom_bus.rom_a}, {16'd0, xa});
        check("rom_b_hold", {16'd0, rom_bus.rom_b}, {16'd0, xb});
      end
      if (done) seen = 1'b1;
    end
    check("done_edge", k, 6);
    check("noe_low_cycles", low, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_fl", {31'd0, fl}, 32'd0);
    check("rst_fv", {31'd0, fv}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_noe", {31'd0, rom_bus.rom_noe}, 32'd1);
    check("rst_rom_a", {16'd0, rom_bus.rom_a}, 32'd0);
    check("rst_rom_op", {29'd0, rom_bus.rom_op}, 32'd0);
    reset = 1'b0;

    op_timed(3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    op_timed(3'b001, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b1, 1'b0, 1'b0);
    op_timed(3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op_timed(3'b000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    op_timed(3'b011, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("done_count_after_ignore", done_cnt, exp_dones);
    op_timed(3'b000, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Abort in the second ACCESS cycle.
    op = 3'b000; a = 16'h1234; b = 16'h1111; flin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check("abort_noe", {31'd0, rom_bus.rom_noe}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_done_count", done_cnt, exp_dones);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_fl", {31'd0, fl}, 32'd0);
    check("abort_fv", {31'd0, fv}, 32'd0);

    mfl = 1'b0; mfv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      logic        rf;
      ro = 3'($urandom_range(0, 4));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 1'($urandom);
      e  = ref_alu(ro, ra, rb, rf, mfl, mfv);
      mfl = e.fl; mfv = e.fv;
      op_timed(ro, ra, rb, rf, e.res, e.fl, e.fv, 1'b0);
    end

`ifdef ALU_FLAG_WRITE_EN
    fl_we = 1'b1; fl_d = 1'b0;
    op_timed(3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("fl_we_idle", {31'd0, fl}, 32'd0);
    fl_we = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("final_done_count", done_cnt, exp_dones);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_seq.md
ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
Parameters:
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, meaning ROM access cycles with noe low before capture (legal range 1-15).
Ports:
REQ-002 SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have reset  input  1  synchronous active-high reset, sampled on clk.
REQ-004 SHALL have start  input  1  request a new ALU operation.
REQ-005 SHALL have op, a, b, flin  inputs  3/16/16/1  operation code, operands, carry-in.
REQ-006 SHALL have rom_noe  output  1  ALU ROM output enable, active low.
REQ-007 SHALL have rom_op, rom_a, rom_b, rom_flin  outputs  3/16/16/1  latched operation presented to the ALU ROM.
REQ-008 SHALL have rom_ibus, rom_flout, rom_nsetl, rom_fvout, rom_nsetv  inputs  16/1/1/1/1  ROM result, L out, L-set strobe (active low), V out, V-set strobe (active low).
REQ-009 SHALL have result  output  16  last captured result.
REQ-010 SHALL have fl, fv  outputs  1/1  Link and Overflow flag registers.
REQ-011 SHALL have busy, done  outputs  1/1  operation in progress; one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, SETUP, ACCESS, CAPTURE.
REQ-013 In IDLE with start=1, SHALL latch op/a/b/flin into rom_* outputs and go to SETUP; start outside IDLE SHALL be ignored.
REQ-014 SETUP SHALL last one cycle with rom_noe=1 (address settle), then go to ACCESS.
REQ-015 ACCESS SHALL hold rom_noe=0 for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to CAPTURE.
REQ-016 CAPTURE SHALL keep rom_noe=0, register rom_ibus into result, then return to IDLE with rom_noe=1.
REQ-017 In CAPTURE, fl SHALL load rom_flout only if rom_nsetl=0, and fv SHALL load rom_fvout only if rom_nsetv=0; otherwise flags hold.
REQ-018 done SHALL be 1 for exactly the one cycle after CAPTURE, i.e. WAIT_CYCLES+3 edges after start is sampled; result/flags valid from that cycle.
REQ-019 busy SHALL be 1 in SETUP, ACCESS, CAPTURE and 0 in IDLE.
REQ-020 start asserted in the done cycle SHALL be accepted (back-to-back operations, no bubble).
REQ-021 rom_op/rom_a/rom_b/rom_flin SHALL stay constant from SETUP through CAPTURE.
REQ-022 result and flags SHALL be unchanged by operations aborted before CAPTURE.

Reset
REQ-023 On reset=1: state IDLE, rom_noe=1, rom_op/rom_a/rom_b/rom_flin=0, result=0, fl=0, fv=0, busy=0, done=0, counter=0.
REQ-024 Reset mid-operation SHALL abort: rom_noe=1 on the next cycle, no done pulse, no flag/result update.

Configuration
REQ-025 Macro ALU_FLAG_WRITE_EN: when defined, SHALL add inputs fl_we, fl_d, fv_we, fv_d loading fl/fv directly in any state; a CAPTURE flag load in the same cycle takes priority; reset still wins over both.
REQ-026 Without ALU_FLAG_WRITE_EN, those ports SHALL be absent and flags change only via CAPTURE or reset.

Structure
REQ-027 Package alu_seq_pkg SHALL hold op-code constants (ADD=000, AND=001, OR=010, XOR=011, NOT=100) and the state encoding.
REQ-028 The wait counter SHALL be a sub-module alu_wait_ctr (load, decrement, zero flag).

Verification (bench uses a behavioural ALU ROM model; WAIT_CYCLES=3)
REQ-029 ADD a=FFFF b=0001 flin=0 -> done at edge 6, result=0000, fl=1, fv=0, rom_noe low exactly 4 cycles.
REQ-030 fl preset 1; AND a=F0F0 b=0FF0 -> result=00F0, fl=1, fv unchanged (nsetl/nsetv high).
REQ-031 ADD a=7FFF b=0001 flin=0 -> result=8000, fv=1, fl=0; then ADD 0000+0000 flin=1 started in done cycle -> result=0001, fv=0, no idle bubble.
REQ-032 start pulsed during ACCESS with different operands -> ignored; rom_a/rom_b unchanged, one done only.
REQ-033 reset asserted in second ACCESS cycle -> rom_noe=1 next cycle, no done, result/fl/fv=0.
REQ-034 With ALU_FLAG_WRITE_EN: fl_we=1 fl_d=0 in CAPTURE of an ADD producing carry -> fl=1; fl_we alone in IDLE -> fl=fl_d next cycle.
